// File: rtl/decode_mul_arbiter_pkg.sv
// Shared types and defaults for the decode-stage multiplier arbiter.
package decode_mul_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int A_WIDTH_DEF = 40;
  localparam int B_WIDTH_DEF = 25;
  localparam int P_WIDTH_DEF = 64;
  // Tag id field is sized for the largest arbiter we expect; tops use the low ID_W bits.
  localparam int TAG_ID_MAX  = 8;

  // Requester-id width for n requesters (at least one bit).
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One stage of the in-flight tag pipeline.
  typedef struct packed {
    logic                  valid;
    logic [TAG_ID_MAX-1:0] id;
  } tag_t;

endpackage

// File: rtl/decode_rr_pick.sv
// Combinational round-robin picker: lowest valid index at or above ptr, wrapping.
module decode_rr_pick
  import decode_mul_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant,
  output logic               any_valid
);

  // Scan offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    int idx;
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        grant     = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decode_mul_arbiter.sv
// Shares one pipelined signed multiplier among NUM_REQ decode requesters.
// Requester ids ride a tag pipeline in lockstep with the multiplier stages;
// response backpressure stalls both through mul_ce.
module decode_mul_arbiter
  import decode_mul_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = id_width(NUM_REQ),
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF,
  parameter int P_WIDTH = P_WIDTH_DEF,
  parameter int MUL_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic                       mul_ce,
  output logic [A_WIDTH-1:0]         mul_din0,
  output logic [B_WIDTH-1:0]         mul_din1,
  input  logic [P_WIDTH-1:0]         mul_dout,
  output logic                       idle
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant;
  logic            any_valid;
  logic            advance;
  tag_t            tag_q [MUL_LAT];

  decode_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // Pipeline moves whenever the last stage is empty or being consumed.
  assign advance   = !tag_q[MUL_LAT-1].valid || rsp_ready;
  assign mul_ce    = advance && !reset;
  assign rsp_valid = tag_q[MUL_LAT-1].valid;
  assign rsp_id    = tag_q[MUL_LAT-1].id[ID_W-1:0];
  assign rsp_p     = mul_dout;

  // Operand mux; zeros on a bubble so the multiplier sees a clean value.
  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    if (any_valid) begin
      mul_din0 = req_a[int'(grant)*A_WIDTH +: A_WIDTH];
      mul_din1 = req_b[int'(grant)*B_WIDTH +: B_WIDTH];
    end
  end

  // One-hot accept for the granted requester when the pipe can take it.
  always_comb begin
    req_ready = '0;
    if (advance && any_valid && !reset) req_ready[grant] = 1'b1;
  end

  // Idle when no stage carries a live tag.
  always_comb begin
    idle = 1'b1;
    for (int s = 0; s < MUL_LAT; s++)
      if (tag_q[s].valid) idle = 1'b0;
  end

  // Tag pipeline and round-robin pointer; both freeze while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      for (int s = 0; s < MUL_LAT; s++) tag_q[s] <= '0;
    end else if (advance) begin
      for (int s = 1; s < MUL_LAT; s++) tag_q[s] <= tag_q[s-1];
      tag_q[0].valid <= any_valid;
      tag_q[0].id    <= any_valid ? TAG_ID_MAX'(grant) : '0;
      if (any_valid)
        ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + ID_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_mul_arbiter.sv
// Self-checking bench: behavioural multiplier, directed checks plus a
// scoreboard of tagged products pushed at accept and popped at response.
module tb_decode_mul_arbiter;

  localparam int NR = 4;
  localparam int AW = 40;
  localparam int BW = 25;
  localparam int PW = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_a;
  logic [NR*BW-1:0]  req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [PW-1:0]     rsp_p;
  logic              mul_ce;
  logic [AW-1:0]     mul_din0;
  logic [BW-1:0]     mul_din1;
  logic [PW-1:0]     mul_dout = '0;
  logic              idle;

  logic signed [AW-1:0] a_arr [NR];
  logic signed [BW-1:0] b_arr [NR];

  typedef struct { logic [1:0] id; logic [PW-1:0] p; } exp_t;
  exp_t sb [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_mul_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .mul_ce(mul_ce), .mul_din0(mul_din0),
    .mul_din1(mul_din1), .mul_dout(mul_dout), .idle(idle)
  );

  // Single-stage signed multiplier with clock-enable.
  always @(posedge clk)
    if (mul_ce) mul_dout <= 64'(longint'($signed(mul_din0)) * longint'($signed(mul_din1)));

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NR; i++) begin
      req_a[i*AW +: AW] = a_arr[i];
      req_b[i*BW +: BW] = b_arr[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: handshakes are evaluated mid-cycle and take effect at the next edge.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_id", 64'(rsp_id), 64'(e.id));
          chk("sb_p", rsp_p, e.p);
        end
      end
      for (int i = 0; i < NR; i++)
        if (req_ready[i]) begin
          exp_t e;
          e.id = 2'(i);
          e.p  = 64'(longint'(a_arr[i]) * longint'(b_arr[i]));
          sb.push_back(e);
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input int idx, input longint a, input longint b,
                        input logic [63:0] expp, input string tag);
    a_arr[idx] = AW'(a);
    b_arr[idx] = BW'(b);
    req_valid  = NR'(1) << idx;
    #1 chk({tag, "_rdy"}, 64'(req_ready), 64'(NR'(1) << idx));
    tick();
    req_valid = '0;
    #1;
    chk({tag, "_vld"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_id"}, 64'(rsp_id), 64'(idx));
    chk({tag, "_p"}, rsp_p, expp);
  endtask

  logic [1:0]    exp_g;
  logic [1:0]    hold_id;
  logic [PW-1:0] hold_p;

  initial begin
    reset = 1'b1; rsp_ready = 1'b1; req_valid = '0;
    for (int i = 0; i < NR; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
    tick(); tick();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mul_ce", 64'(mul_ce), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    reset = 1'b0;

    // Single request, then idle two cycles after issue.
    single(2, 3, -5, 64'hFFFF_FFFF_FFFF_FFF1, "single");
    tick();
    chk("single_idle", 64'(idle), 64'd1);
    chk("single_done", 64'(rsp_valid), 64'd0);

    // Fairness: grant 1, then {1,3} -> 3 then 1, then only 0 with ptr=2 -> wrap.
    req_valid = 4'b0010; #1 chk("fair_g1", 64'(req_ready), 64'b0010);
    tick(); req_valid = 4'b1010; #1 chk("fair_g3", 64'(req_ready), 64'b1000);
    tick(); req_valid = 4'b0010; #1 chk("fair_g1b", 64'(req_ready), 64'b0010);
    tick(); req_valid = 4'b0001; #1 chk("fair_wrap", 64'(req_ready), 64'b0001);
    tick(); req_valid = '0;

    // All requesters streaming, with a 3-cycle response stall in the middle.
    exp_g = 2'd1;
    for (int i = 0; i < 12; i++) begin
      tick();
      for (int k = 0; k < NR; k++) begin
        a_arr[k] = AW'(longint'($urandom) - 64'sd2147483648);
        b_arr[k] = BW'($urandom);
      end
      req_valid = 4'hF;
      rsp_ready = !(i >= 4 && i < 7);
      #1;
      if (rsp_ready) begin
        chk("rr_grant", 64'(req_ready), 64'(4'b0001 << exp_g));
        exp_g = exp_g + 2'd1;
      end else begin
        chk("bp_ce", 64'(mul_ce), 64'd0);
        chk("bp_rdy", 64'(req_ready), 64'd0);
        if (i == 4) begin
          chk("bp_vld", 64'(rsp_valid), 64'd1);
          hold_id = rsp_id;
          hold_p  = rsp_p;
        end else begin
          chk("bp_id_hold", 64'(rsp_id), 64'(hold_id));
          chk("bp_p_hold", rsp_p, hold_p);
        end
      end
    end
    tick(); req_valid = '0; rsp_ready = 1'b1;
    for (int i = 0; i < 4 && !(idle && sb.size() == 0); i++) tick();
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // Operand extremes.
    single(0, -(64'sd1 <<< 39), (64'sd1 <<< 24) - 1, 64'h8000_0080_0000_0000, "ext_big");
    tick();
    single(3, -1, -1, 64'd1, "ext_m1");
    tick();

    // Reset while a product is stalled in the pipe.
    rsp_ready = 1'b0; a_arr[1] = 40'sd7; b_arr[1] = 25'sd9; req_valid = 4'b0010;
    tick(); req_valid = '0;
    chk("rstmid_stalled", 64'(rsp_valid), 64'd1);
    reset = 1'b1;
    tick();
    chk("rstmid_vld", 64'(rsp_valid), 64'd0);
    chk("rstmid_idle", 64'(idle), 64'd1);
    reset = 1'b0; rsp_ready = 1'b1; req_valid = 4'b1001;
    #1 chk("rstmid_ptr0", 64'(req_ready), 64'b0001);
    tick(); req_valid = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("rstmid_drained", 64'(sb.size()), 64'd0);
    chk("rstmid_idle_end", 64'(idle), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
